// File: rtl/time_edit_ctrl.sv
// Time/alarm edit controller for a clock display.
// The user sets the time of day (SETT) or the alarm (SETA) field by field
// with five buttons, and the selected field blinks on the display.
// Time commits go to the timekeeper as a one-cycle LOAD_TIME strobe;
// alarm commits are held here and compared against the running time.
module time_edit_ctrl #(
  parameter int         BLINK_HALF = 5000,
  parameter logic [6:0] BLANK_CODE = 7'd90
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       chmod,
  input  logic       OK,
  input  logic       shift,
  input  logic       up,
  input  logic       down,
  input  logic [6:0] HOUR,
  input  logic [6:0] MIN,
  input  logic [6:0] SEC,
  output logic [1:0] MODE,
  output logic [1:0] FIELD,
  output logic [6:0] DISP_HOUR,
  output logic [6:0] DISP_MIN,
  output logic [6:0] DISP_SEC,
  output logic       LOAD_TIME,
  output logic [6:0] NEW_HOUR,
  output logic [6:0] NEW_MIN,
  output logic [6:0] NEW_SEC,
  output logic [6:0] ALM_HOUR,
  output logic [6:0] ALM_MIN,
  output logic [6:0] ALM_SEC,
  output logic       ALM_VALID,
  output logic       ALM_HIT
);

  typedef enum logic [1:0] {NORM = 2'd0, SETT = 2'd1, SETA = 2'd2} mode_t;

  localparam int                CNT_W    = $clog2(2 * BLINK_HALF);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BLINK_HALF);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(2 * BLINK_HALF - 1);
  localparam logic [6:0]        HOUR_MAX = 7'd23;
  localparam logic [6:0]        MS_MAX   = 7'd59;

  mode_t            mode;
  logic [4:0]       btn, prev_btn, press;
  logic [CNT_W-1:0] blink;
  logic             blank;

  assign MODE  = mode;
  assign btn   = {chmod, OK, shift, up, down};
  assign press = btn & ~prev_btn;
  assign blank = (blink >= CNT_HALF);

  // One up/down step with wrap; out-of-range values snap to 0 (up) or max (down).
  function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] mx,
                                      input logic inc);
    if (inc) return (v >= mx) ? 7'd0 : v + 7'd1;
    else     return (v == 7'd0 || v > mx) ? mx : v - 7'd1;
  endfunction

  // Mode FSM, edit/alarm registers, blink counter and press edge detection.
  // Only the highest-priority press in a cycle is acted on.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      mode      <= NORM;
      FIELD     <= 2'd0;
      prev_btn  <= '0;
      blink     <= '0;
      LOAD_TIME <= 1'b0;
      NEW_HOUR  <= '0;
      NEW_MIN   <= '0;
      NEW_SEC   <= '0;
      ALM_HOUR  <= '0;
      ALM_MIN   <= '0;
      ALM_SEC   <= '0;
      ALM_VALID <= 1'b0;
    end else begin
      prev_btn  <= btn;
      LOAD_TIME <= 1'b0;
      if (mode == NORM || blink == CNT_MAX) blink <= '0;
      else                                  blink <= blink + CNT_W'(1);

      if (press[4]) begin
        blink <= '0;
        case (mode)
          NORM: begin
            mode     <= SETT;
            FIELD    <= 2'd1;
            NEW_HOUR <= HOUR;
            NEW_MIN  <= MIN;
            NEW_SEC  <= SEC;
          end
          SETT: begin
            mode     <= SETA;
            FIELD    <= 2'd1;
            NEW_HOUR <= ALM_HOUR;
            NEW_MIN  <= ALM_MIN;
            NEW_SEC  <= ALM_SEC;
          end
          default: begin
            mode  <= NORM;
            FIELD <= 2'd0;
          end
        endcase
      end else if (press[3]) begin
        if (mode == SETT) begin
          LOAD_TIME <= 1'b1;
          mode      <= NORM;
          FIELD     <= 2'd0;
        end else if (mode == SETA) begin
          ALM_HOUR  <= NEW_HOUR;
          ALM_MIN   <= NEW_MIN;
          ALM_SEC   <= NEW_SEC;
          ALM_VALID <= 1'b1;
          mode      <= NORM;
          FIELD     <= 2'd0;
        end
      end else if (press[2]) begin
        if (mode != NORM) FIELD <= (FIELD == 2'd3) ? 2'd1 : FIELD + 2'd1;
      end else if (press[1] || press[0]) begin
        // Any adjustment restarts the blink so the new value is seen at once;
        // up and down together cancel but still restart it.
        blink <= '0;
        if (mode != NORM && !(press[1] && press[0])) begin
          case (FIELD)
            2'd1:    NEW_HOUR <= step(NEW_HOUR, HOUR_MAX, press[1]);
            2'd2:    NEW_MIN  <= step(NEW_MIN,  MS_MAX,   press[1]);
            2'd3:    NEW_SEC  <= step(NEW_SEC,  MS_MAX,   press[1]);
            default: ;
          endcase
        end
      end
    end
  end

  // Display mux: live time in NORM, edit registers with blinking field otherwise.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      DISP_HOUR <= '0;
      DISP_MIN  <= '0;
      DISP_SEC  <= '0;
    end else if (mode == NORM) begin
      DISP_HOUR <= HOUR;
      DISP_MIN  <= MIN;
      DISP_SEC  <= SEC;
    end else begin
      DISP_HOUR <= (blank && FIELD == 2'd1) ? BLANK_CODE : NEW_HOUR;
      DISP_MIN  <= (blank && FIELD == 2'd2) ? BLANK_CODE : NEW_MIN;
      DISP_SEC  <= (blank && FIELD == 2'd3) ? BLANK_CODE : NEW_SEC;
    end
  end

  // Alarm match, evaluated in every mode.
  always_ff @(posedge CLK) begin
    if (!RESETN) ALM_HIT <= 1'b0;
    else         ALM_HIT <= ALM_VALID && HOUR == ALM_HOUR && MIN == ALM_MIN &&
                            SEC == ALM_SEC;
  end

endmodule

// File: tb/tb_time_edit_ctrl.sv
// Directed bench for time_edit_ctrl: time set, wrap, alarm, blink,
// simultaneous presses and reset during an edit.
module tb_time_edit_ctrl;

  localparam logic [4:0] B_CHMOD = 5'b10000;
  localparam logic [4:0] B_OK    = 5'b01000;
  localparam logic [4:0] B_SHIFT = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [4:0] btn;
  logic [6:0] HOUR, MIN, SEC;
  logic [1:0] MODE, FIELD;
  logic [6:0] DISP_HOUR, DISP_MIN, DISP_SEC;
  logic       LOAD_TIME;
  logic [6:0] NEW_HOUR, NEW_MIN, NEW_SEC;
  logic [6:0] ALM_HOUR, ALM_MIN, ALM_SEC;
  logic       ALM_VALID, ALM_HIT;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;

  time_edit_ctrl #(.BLINK_HALF(4), .BLANK_CODE(7'd90)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .chmod(btn[4]), .OK(btn[3]), .shift(btn[2]), .up(btn[1]), .down(btn[0]),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC),
    .MODE(MODE), .FIELD(FIELD),
    .DISP_HOUR(DISP_HOUR), .DISP_MIN(DISP_MIN), .DISP_SEC(DISP_SEC),
    .LOAD_TIME(LOAD_TIME),
    .NEW_HOUR(NEW_HOUR), .NEW_MIN(NEW_MIN), .NEW_SEC(NEW_SEC),
    .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN), .ALM_SEC(ALM_SEC),
    .ALM_VALID(ALM_VALID), .ALM_HIT(ALM_HIT)
  );

  always #5 CLK = ~CLK;

  // Count LOAD_TIME strobe cycles, sampled mid-cycle.
  always @(negedge CLK) if (LOAD_TIME) load_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Press for one edge, release for one edge; returns 1ns after the second edge.
  task automatic press(input logic [4:0] b);
    @(negedge CLK); btn = b;
    @(posedge CLK); #1 btn = '0;
    @(posedge CLK); #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    @(negedge CLK);
    HOUR = 7'(h); MIN = 7'(m); SEC = 7'(s);
  endtask

  initial begin
    RESETN = 1'b0; btn = '0;
    HOUR = 7'd10; MIN = 7'd20; SEC = 7'd30;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_mode", MODE, 0);
    chk("rst_field", FIELD, 0);
    chk("rst_disp_hour", DISP_HOUR, 0);
    chk("rst_alm_valid", ALM_VALID, 0);
    chk("rst_load", LOAD_TIME, 0);
    @(negedge CLK); RESETN = 1'b1;
    @(posedge CLK); #1;
    chk("norm_disp_hour", DISP_HOUR, 10);
    chk("norm_disp_sec", DISP_SEC, 30);

    // Time set: 10:20:30 -> 10:23:30
    press(B_CHMOD);
    chk("sett_mode", MODE, 1);
    chk("sett_field", FIELD, 1);
    chk("sett_new_hour", NEW_HOUR, 10);
    chk("sett_new_min", NEW_MIN, 20);
    press(B_SHIFT);
    chk("shift_field", FIELD, 2);
    repeat (3) press(B_UP);
    chk("up3_min", NEW_MIN, 23);
    chk("pre_ok_loads", load_cnt, 0);
    press(B_OK);
    chk("ok_loads", load_cnt, 1);
    chk("ok_load_low", LOAD_TIME, 0);
    chk("ok_mode", MODE, 0);
    chk("ok_field", FIELD, 0);
    chk("ok_new_hour", NEW_HOUR, 10);
    chk("ok_new_min", NEW_MIN, 23);
    chk("ok_new_sec", NEW_SEC, 30);

    // Wrap cases
    set_time(23, 0, 5);
    press(B_CHMOD);
    chk("wrap_h_load", NEW_HOUR, 23);
    press(B_UP);
    chk("wrap_h_up", NEW_HOUR, 0);
    press(B_SHIFT);
    press(B_DOWN);
    chk("wrap_m_down", NEW_MIN, 59);
    press(B_CHMOD);
    chk("seta_mode", MODE, 2);
    chk("seta_no_load", load_cnt, 1);
    press(B_CHMOD);
    chk("back_norm", MODE, 0);
    set_time(30, 0, 5);
    press(B_CHMOD);
    press(B_DOWN);
    chk("wrap_h30_down", NEW_HOUR, 23);
    press(B_CHMOD);
    press(B_CHMOD);
    chk("wrap_exit_mode", MODE, 0);

    // Alarm commit 06:30:00
    set_time(6, 29, 59);
    press(B_CHMOD);
    press(B_CHMOD);
    chk("alm_mode", MODE, 2);
    chk("alm_field", FIELD, 1);
    chk("alm_edit_init", NEW_HOUR, 0);
    repeat (6) press(B_UP);
    press(B_SHIFT);
    repeat (30) press(B_UP);
    press(B_OK);
    chk("alm_valid", ALM_VALID, 1);
    chk("alm_hour", ALM_HOUR, 6);
    chk("alm_min", ALM_MIN, 30);
    chk("alm_sec", ALM_SEC, 0);
    chk("alm_mode_norm", MODE, 0);
    chk("alm_no_load", load_cnt, 1);
    chk("alm_hit_early", ALM_HIT, 0);
    set_time(6, 30, 0);
    #1 chk("alm_hit_same_cycle", ALM_HIT, 0);
    @(posedge CLK); #1;
    chk("alm_hit", ALM_HIT, 1);
    set_time(6, 30, 1);
    @(posedge CLK); #1;
    chk("alm_hit_clear", ALM_HIT, 0);

    // Blink on the minute field, BLINK_HALF=4
    set_time(12, 40, 0);
    press(B_CHMOD);
    press(B_SHIFT);
    chk("blink_field", FIELD, 2);
    press(B_UP);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) begin
        @(posedge CLK); #1;
      end
      chk($sformatf("blink_k%0d", k), DISP_MIN, (((k - 1) % 8) >= 4) ? 90 : 41);
    end
    chk("blink_hour_steady", DISP_HOUR, 12);
    repeat (5) @(posedge CLK);
    #1 chk("blink_blank", DISP_MIN, 90);
    press(B_UP);
    chk("blink_restart", DISP_MIN, 42);
    press(B_CHMOD);
    press(B_CHMOD);

    // Simultaneous presses
    press(B_CHMOD);
    press(B_CHMOD | B_OK);
    chk("sim_mode", MODE, 2);
    chk("sim_no_load", load_cnt, 1);
    chk("sim_hour_init", NEW_HOUR, 6);
    press(B_UP | B_DOWN);
    chk("sim_updown", NEW_HOUR, 6);
    press(B_CHMOD);

    // Reset mid-edit with an OK press in the reset cycle
    set_time(9, 8, 7);
    press(B_CHMOD);
    press(B_UP);
    chk("mid_edit_hour", NEW_HOUR, 10);
    @(negedge CLK); RESETN = 1'b0; btn = B_OK;
    @(posedge CLK); #1;
    chk("mr_mode", MODE, 0);
    chk("mr_field", FIELD, 0);
    chk("mr_new_hour", NEW_HOUR, 0);
    chk("mr_alm_valid", ALM_VALID, 0);
    chk("mr_alm_min", ALM_MIN, 0);
    chk("mr_disp_hour", DISP_HOUR, 0);
    chk("mr_load", LOAD_TIME, 0);
    chk("mr_hit", ALM_HIT, 0);
    btn = '0;
    @(negedge CLK); RESETN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("mr_loads_total", load_cnt, 1);
    chk("mr_disp_after", DISP_HOUR, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
